ysyx_22040895_exu_ctrl: RTL

- Execute-stage sequencer for the RV64 core.
- Accepts one decoded op at a time from IDU over a valid/ready handshake.
- Single-cycle ALU/BCU ops complete directly. Multiply/divide ops are handed to the iterative MDU over a start/done handshake.
- Presents a registered result, destination and branch redirect to LSU/WBU over a second valid/ready handshake; supports pipeline flush and an MDU timeout watchdog.

---
 rtl/ysyx_22040895_exu_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040895_exu_ctrl.sv
// Execute-stage sequencer: takes one decoded op from IDU, runs multiply/divide ops
// through the iterative MDU, and hands a registered result/redirect to LSU/WBU.
module ysyx_22040895_exu_ctrl #(
  parameter int MD_TIMEOUT = 80,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i_ctrl,
  output logic            in_ready_o_ctrl,
  input  logic            is_md_i_ctrl,
  input  logic [XLEN-1:0] alu_result_i_ctrl,
  input  logic            jump_branch_i_ctrl,
  input  logic [XLEN-1:0] dnpc_i_ctrl,
  input  logic [4:0]      rd_i_ctrl,
  input  logic            wen_i_ctrl,
  output logic            md_start_o_ctrl,
  output logic            md_kill_o_ctrl,
  input  logic            md_done_i_ctrl,
  input  logic [XLEN-1:0] md_result_i_ctrl,
  input  logic            flush_i_ctrl,
  output logic            out_valid_o_ctrl,
  input  logic            out_ready_i_ctrl,
  output logic [XLEN-1:0] out_result_o_ctrl,
  output logic [4:0]      out_rd_o_ctrl,
  output logic            out_wen_o_ctrl,
  output logic            redirect_o_ctrl,
  output logic [XLEN-1:0] redirect_pc_o_ctrl,
  output logic            err_o_ctrl
);

  localparam int            CW       = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_ISSUE = 2'd1,
    MD_WAIT  = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            md_start_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_result_r;
  logic [4:0]      out_rd_r;
  logic            out_wen_r;
  logic            redirect_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic            err_r;

  logic in_ready_s;
  logic accept_s;
  logic md_busy_s;
  logic timeout_s;
  logic md_kill_s;

  // Handshake qualifiers and the same-cycle MDU abort (flush or watchdog; never during reset)
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    md_busy_s  = 1'b0;
    timeout_s  = 1'b0;
    md_kill_s  = 1'b0;
    in_ready_s = rst & (state_r == IDLE);
    accept_s   = in_valid_i_ctrl & in_ready_s & ~flush_i_ctrl;
    md_busy_s  = (state_r == MD_ISSUE) | (state_r == MD_WAIT);
    timeout_s  = (state_r == MD_WAIT) & ~md_done_i_ctrl & (cnt_r == CNT_LAST);
    md_kill_s  = rst & md_busy_s & (flush_i_ctrl | timeout_s);
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      md_start_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_result_r  <= {XLEN{1'b0}};
      out_rd_r      <= 5'd0;
      out_wen_r     <= 1'b0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= {XLEN{1'b0}};
      err_r         <= 1'b0;
    end else if (flush_i_ctrl) begin
      state_r     <= IDLE;
      md_start_r  <= 1'b0;
      out_valid_r <= 1'b0;
      redirect_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          md_start_r <= 1'b0;
          if (accept_s) begin
            out_rd_r      <= rd_i_ctrl;
            out_wen_r     <= wen_i_ctrl;
            redirect_pc_r <= dnpc_i_ctrl;
            if (is_md_i_ctrl) begin
              redirect_r <= 1'b0;
              md_start_r <= 1'b1;
              state_r    <= MD_ISSUE;
            end else begin
              out_result_r <= alu_result_i_ctrl;
              redirect_r   <= jump_branch_i_ctrl;
              out_valid_r  <= 1'b1;
              state_r      <= RESP;
            end
          end
        end
        MD_ISSUE: begin
          // done here would be a protocol violation, so it is not looked at
          md_start_r <= 1'b0;
          cnt_r      <= {CW{1'b0}};
          state_r    <= MD_WAIT;
        end
        MD_WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (md_done_i_ctrl) begin
            out_result_r <= md_result_i_ctrl;
            out_valid_r  <= 1'b1;
            state_r      <= RESP;
          end else if (timeout_s) begin
            out_result_r <= {XLEN{1'b1}};
            err_r        <= 1'b1;
            out_valid_r  <= 1'b1;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (out_ready_i_ctrl) begin
            out_valid_r <= 1'b0;
            redirect_r  <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          redirect_r  <= 1'b0;
          md_start_r  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o_ctrl    = in_ready_s;
  assign md_start_o_ctrl    = md_start_r;
  assign md_kill_o_ctrl     = md_kill_s;
  assign out_valid_o_ctrl   = out_valid_r;
  assign out_result_o_ctrl  = out_result_r;
  assign out_rd_o_ctrl      = out_rd_r;
  assign out_wen_o_ctrl     = out_wen_r;
  assign redirect_o_ctrl    = redirect_r;
  assign redirect_pc_o_ctrl = redirect_pc_r;
  assign err_o_ctrl         = err_r;

endmodule
